// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin request arbiter and sequencer for the shared subtractive GCD datapath
// One job in flight: IDLE grants, LOAD_A/LOAD_B seed the datapath, ITER subtracts until equal, RESP returns.
module gcd_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_gcd,
  output logic              busy,
  output logic              dp_ldA,
  output logic              dp_ldB,
  output logic              dp_sel1,
  output logic              dp_sel2,
  output logic              dp_sel_in,
  output logic [W-1:0]      dp_data_in,
  input  logic              dp_lt,
  input  logic              dp_gt,
  input  logic              dp_eq,
  input  logic [W-1:0]      dp_aout
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ITER, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic [W-1:0]    grant_a, grant_b;
  logic [NREQ-1:0] grant_vec;

  // Search from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign grant_a = req_a[grant_idx*W +: W];
  assign grant_b = req_b[grant_idx*W +: W];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    grant_vec  = '0;
    dp_ldA     = 1'b0;
    dp_ldB     = 1'b0;
    dp_sel1    = 1'b0;
    dp_sel2    = 1'b0;
    dp_sel_in  = 1'b0;
    dp_data_in = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          grant_vec[grant_idx] = 1'b1;
          id_d  = grant_idx;
          a_d   = grant_a;
          b_d   = grant_b;
          ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
          // A zero operand would never reach equality by subtraction.
          if (grant_a == '0 || grant_b == '0) begin
            res_d   = grant_a | grant_b;
            state_d = RESP;
          end else begin
            state_d = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        dp_data_in = a_q;
        dp_ldA     = 1'b1;
        state_d    = LOAD_B;
      end
      LOAD_B: begin
        dp_data_in = b_q;
        dp_ldB     = 1'b1;
        state_d    = ITER;
      end
      ITER: begin
        if (dp_eq) begin
          res_d   = dp_aout;
          state_d = RESP;
        end else if (dp_gt) begin
          dp_sel_in = 1'b1;
          dp_ldA    = 1'b1;
        end else if (dp_lt) begin
          dp_sel1   = 1'b1;
          dp_sel2   = 1'b1;
          dp_sel_in = 1'b1;
          dp_ldB    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Grant is combinational from req_valid, so it is masked while reset is held.
  assign req_ready  = rst_n ? grant_vec : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_gcd   = res_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb/tb_gcd_scheduler.sv - directed-vector bench for gcd_scheduler with a behavioural GCD datapath
module tb_gcd_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_gcd;
  logic              busy;
  logic              dp_ldA, dp_ldB, dp_sel1, dp_sel2, dp_sel_in;
  logic [W-1:0]      dp_data_in;
  logic              dp_lt, dp_gt, dp_eq;
  logic [W-1:0]      dp_aout;

  gcd_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_gcd(resp_gcd),
    .busy(busy),
    .dp_ldA(dp_ldA), .dp_ldB(dp_ldB), .dp_sel1(dp_sel1), .dp_sel2(dp_sel2),
    .dp_sel_in(dp_sel_in), .dp_data_in(dp_data_in),
    .dp_lt(dp_lt), .dp_gt(dp_gt), .dp_eq(dp_eq), .dp_aout(dp_aout)
  );

  always #5 clk = ~clk;

  // Datapath: unreset A/B registers, operand muxes, subtractor, comparator.
  logic [W-1:0] dpa, dpb, dp_sub;
  assign dp_sub  = (dp_sel1 ? dpb : dpa) - (dp_sel2 ? dpa : dpb);
  assign dp_lt   = dpa < dpb;
  assign dp_gt   = dpa > dpb;
  assign dp_eq   = dpa == dpb;
  assign dp_aout = dpa;
  always @(posedge clk) begin
    if (dp_ldA) dpa <= dp_sel_in ? dp_sub : dp_data_in;
    if (dp_ldB) dpb <= dp_sel_in ? dp_sub : dp_data_in;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int             j_lat, j_lda_cyc, j_ldb_cyc, j_it_lda, j_it_ldb, j_any_ld;
  logic [7:0]     j_seq;
  logic [IDW-1:0] j_id;
  logic [W-1:0]   j_gcd;

  // Present a request just after a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int cyc;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid[idx]    = 1'b1;
    #1;
    cyc = 0;
    while (!req_ready[idx] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    ok = req_ready[idx];
    if (!ok) expect_eq("accept_timeout", 0, 1);
    else expect_eq($sformatf("grant_onehot_r%0d", idx), 32'(req_ready), 32'(1 << idx));
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic do_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    int n;
    j_lat = -1; j_lda_cyc = -1; j_ldb_cyc = -1;
    j_it_lda = 0; j_it_ldb = 0; j_any_ld = 0; j_seq = '0; j_id = '0; j_gcd = '0;
    issue(idx, a, b, ok);
    if (!ok) return;
    n = 1;
    while (n < 70000) begin
      if (dp_ldA || dp_ldB) j_any_ld++;
      if (dp_ldA && !dp_sel_in) j_lda_cyc = n;
      if (dp_ldB && !dp_sel_in) j_ldb_cyc = n;
      if (dp_sel_in && (dp_ldA || dp_ldB)) begin
        j_it_lda += int'(dp_ldA);
        j_it_ldb += int'(dp_ldB);
        j_seq = {j_seq[6:0], dp_ldB};
      end
      if (resp_valid) begin
        j_lat = n;
        j_id  = resp_id;
        j_gcd = resp_gcd;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (j_lat < 0) expect_eq("resp_timeout", 0, 1);
    @(negedge clk);
  endtask

  bit ok;
  int stray, n_grant, n_resp;
  int grant_log[5];
  logic [W-1:0] rr_exp[NREQ];

  initial begin
    // Reset values with requests pending.
    req_valid = 4'b0101;
    #12;
    expect_eq("rst_req_ready", 32'(req_ready), 0);
    expect_eq("rst_resp_valid", 32'(resp_valid), 0);
    expect_eq("rst_busy", 32'(busy), 0);
    expect_eq("rst_resp_id", 32'(resp_id), 0);
    expect_eq("rst_resp_gcd", 32'(resp_gcd), 0);
    expect_eq("rst_dp_ctl", 32'({dp_ldA, dp_ldB, dp_sel1, dp_sel2, dp_sel_in}), 0);
    expect_eq("rst_dp_data", 32'(dp_data_in), 0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    do_job(0, 16'd143, 16'd78);
    expect_eq("j143_gcd", 32'(j_gcd), 13);
    expect_eq("j143_id", 32'(j_id), 0);
    expect_eq("j143_lat", j_lat, 10);
    expect_eq("j143_ldA_cyc", j_lda_cyc, 1);
    expect_eq("j143_ldB_cyc", j_ldb_cyc, 2);
    expect_eq("j143_iter_ldA", j_it_lda, 5);
    expect_eq("j143_iter_ldB", j_it_ldb, 1);
    expect_eq("j143_iter_seq", 32'(j_seq), 32'h10);

    do_job(1, 16'd0, 16'd35);
    expect_eq("z35_gcd", 32'(j_gcd), 35);
    expect_eq("z35_id", 32'(j_id), 1);
    expect_eq("z35_lat", j_lat, 1);
    expect_eq("z35_loads", j_any_ld, 0);

    do_job(2, 16'd0, 16'd0);
    expect_eq("zz_gcd", 32'(j_gcd), 0);
    expect_eq("zz_lat", j_lat, 1);
    expect_eq("zz_loads", j_any_ld, 0);

    do_job(3, 16'd21, 16'd21);
    expect_eq("eq21_gcd", 32'(j_gcd), 21);
    expect_eq("eq21_id", 32'(j_id), 3);
    expect_eq("eq21_lat", j_lat, 4);
    expect_eq("eq21_iter_loads", j_it_lda + j_it_ldb, 0);

    do_job(0, 16'd65535, 16'd1);
    expect_eq("big_gcd", 32'(j_gcd), 1);
    expect_eq("big_iter_ldA", j_it_lda, 65534);
    expect_eq("big_iter_ldB", j_it_ldb, 0);
    expect_eq("big_lat", j_lat, 65538);

    // Backpressure: ptr is 1, so r2 beats r3.
    resp_ready = 1'b0;
    req_a[3*W +: W] = 16'd9;
    req_b[3*W +: W] = 16'd3;
    req_valid[3] = 1'b1;
    issue(2, 16'd48, 16'd18, ok);
    for (int c = 0; c < 50 && !resp_valid; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      expect_eq($sformatf("bp_valid_%0d", c), 32'(resp_valid), 1);
      expect_eq($sformatf("bp_id_%0d", c), 32'(resp_id), 2);
      expect_eq($sformatf("bp_gcd_%0d", c), 32'(resp_gcd), 6);
      expect_eq($sformatf("bp_req_ready_%0d", c), 32'(req_ready), 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    expect_eq("bp_done_valid", 32'(resp_valid), 0);
    expect_eq("bp_next_grant", 32'(req_ready), 32'h8);
    req_valid = '0;
    @(negedge clk);

    // Asynchronous reset while holding a response.
    resp_ready = 1'b0;
    issue(1, 16'd5, 16'd0, ok);
    expect_eq("ar_pre_valid", 32'(resp_valid), 1);
    expect_eq("ar_pre_gcd", 32'(resp_gcd), 5);
    req_valid[2] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    expect_eq("ar_resp_valid", 32'(resp_valid), 0);
    expect_eq("ar_busy", 32'(busy), 0);
    expect_eq("ar_resp_id", 32'(resp_id), 0);
    expect_eq("ar_resp_gcd", 32'(resp_gcd), 0);
    expect_eq("ar_req_ready", 32'(req_ready), 0);
    expect_eq("ar_dp_ctl", 32'({dp_ldA, dp_ldB, dp_sel1, dp_sel2, dp_sel_in}), 0);
    @(negedge clk);
    req_valid = '0;
    resp_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during ITER abandons the job.
    issue(0, 16'd143, 16'd78, ok);
    repeat (3) @(negedge clk);
    expect_eq("ri_in_iter", 32'(dp_sel_in), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) stray++;
      @(negedge clk);
    end
    expect_eq("ri_no_resp", stray, 0);
    do_job(1, 16'd48, 16'd18);
    expect_eq("ri_fresh_gcd", 32'(j_gcd), 6);
    expect_eq("ri_fresh_id", 32'(j_id), 1);

    // Round robin from ptr 0 with all requesters pending.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rr_exp[0] = 16'd4; rr_exp[1] = 16'd3; rr_exp[2] = 16'd7; rr_exp[3] = 16'd5;
    req_a = {16'd10, 16'd7, 16'd9, 16'd12};
    req_b = {16'd25, 16'd0, 16'd6, 16'd8};
    req_valid = 4'hF;
    n_grant = 0;
    n_resp = 0;
    #1;
    for (int c = 0; c < 300 && n_grant < 5; c++) begin
      if (req_ready != '0) begin
        expect_eq($sformatf("rr_onehot_%0d", n_grant), 32'($onehot(req_ready)), 1);
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log[n_grant] = i;
        n_grant++;
      end
      if (resp_valid) begin
        expect_eq($sformatf("rr_gcd_id%0d", resp_id), 32'(resp_gcd), 32'(rr_exp[resp_id]));
        n_resp++;
      end
      if (n_grant < 5) @(negedge clk);
    end
    req_valid = '0;
    expect_eq("rr_grants", n_grant, 5);
    expect_eq("rr_resps", n_resp, 4);
    expect_eq("rr_order_0", grant_log[0], 0);
    expect_eq("rr_order_1", grant_log[1], 1);
    expect_eq("rr_order_2", grant_log[2], 2);
    expect_eq("rr_order_3", grant_log[3], 3);
    expect_eq("rr_order_4", grant_log[4], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Sequencer and round-robin arbiter for the shared repeated-subtraction GCD datapath (two load-enabled registers A/B, operand muxes, subtractor, lt/gt/eq comparator). It accepts GCD requests from NREQ requesters, grants one at a time, and drives the datapath control lines (ldA, ldB, sel1, sel2, sel_in, dataIn). When A == B it returns the result with the requester id over a valid/ready response channel. It replaces per-user hand-sequenced controllers, so one datapath instance can serve several clients.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/result width; must match datapath
- IDW, 2, id width, clog2(NREQ)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_ready  out  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i] at the clock edge
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  IDW  index of the requester served
- resp_gcd  out  W  GCD result
- busy  out  1  high in every state except IDLE
- dp_ldA, dp_ldB  out  1 each  datapath register load enables
- dp_sel1, dp_sel2, dp_sel_in  out  1 each  datapath mux selects
- dp_data_in  out  W  datapath external input
- dp_lt, dp_gt, dp_eq  in  1 each  datapath compare of A vs B
- dp_aout  in  W  datapath A register

## Operation
- States: IDLE, LOAD_A, LOAD_B, ITER, RESP.
- IDLE
  - Pick the winner round-robin among the set req_valid bits, searching from pointer ptr upward with wrap-around.
  - Assert req_ready[winner] combinationally. At the edge: latch id, a and b; set ptr = (winner+1) mod NREQ.
  - If a == 0 or b == 0: set result = a | b (0 if both are 0), go to RESP. This guards the non-terminating zero case.
  - Otherwise go to LOAD_A.
- LOAD_A: dp_sel_in=0, dp_data_in=a, dp_ldA=1. Go to LOAD_B.
- LOAD_B: dp_sel_in=0, dp_data_in=b, dp_ldB=1. Go to ITER.
- ITER: outputs decoded combinationally from the flags (Mealy).
  - eq: no load; latch result = dp_aout; go to RESP.
  - gt: sel1=0, sel2=0, sel_in=1, ldA=1, so A <= A-B. Stay in ITER.
  - lt: sel1=1, sel2=1, sel_in=1, ldB=1, so B <= B-A. Stay in ITER.
- RESP
  - resp_valid=1; resp_id and resp_gcd come from registers and stay stable until the handshake.
  - On resp_valid & resp_ready: go to IDLE.
  - No request is accepted in RESP. The next accept is no earlier than the cycle after the return to IDLE.
- Defaults in every state/condition not listed above: all dp_* controls 0, dp_data_in 0, req_ready 0.
- Arithmetic is unsigned W-bit. Only the larger value is ever reduced, so no underflow occurs.
- Requesters must hold valid and operands stable until accepted. Deasserting before accept is allowed: that requester is simply not granted.

## Timing
- Reset (async assert, sync release):
  - state IDLE, ptr 0
  - resp_valid 0, resp_id 0, resp_gcd 0, busy 0, req_ready 0
  - all dp_* outputs 0, latched operands 0
- Reset mid-operation abandons the job with no response. The datapath registers have no reset; the next job reloads both A and B.
- Latency, accept at edge T:
  - Nonzero operands: ldA at cycle T+1, ldB at T+2, ITER from T+3. After k subtraction steps eq is seen at T+3+k, and resp_valid rises at T+4+k.
  - Zero operand: resp_valid at T+1, with no dp load asserted.
- Throughput: one job in flight. Minimum accept-to-accept time is 5+k cycles with resp_ready held high.
- Simultaneous requests: exactly one req_ready bit is set per accept. A requester waits at most NREQ-1 grants (starvation bound).

## Test plan
- Reset check: assert rst_n=0 mid-clock → all outputs take their reset values immediately (asynchronously).
- Single request, requester 0, a=143, b=78, resp_ready=1:
  - resp_gcd=13, resp_id=0
  - resp_valid at T+10
  - exactly 6 ITER cycles with a load: ldA, ldB, then ldA ×4
- Boundary operands:
  - (0,35) → 35 at T+1
  - (0,0) → 0
  - (21,21) → 21 at T+4 with no load in ITER
  - (65535,1) → 1, after 65534 ldA steps
- Round-robin fairness: all 4 requesters valid continuously with distinct operands → grant order 0,1,2,3,0. Every resp_id matches its own operand's GCD.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_id and resp_gcd stay stable; req_ready stays 0; the handshake then completes.
- Reset during ITER of (143,78): rst_n low 2 cycles → no response. A fresh (48,18) request → resp_gcd=6.
